// File: rtl/tensor_pkg.sv
`default_nettype none
// ============================================================================
// tensor_pkg : default tensor geometry, build FSM state type, index widths
// Rev 1.0
// ============================================================================
package tensor_pkg;

   localparam int DEF_WIDTH    = 17;
   localparam int DEF_ROWS     = 8;
   localparam int DEF_COLS     = 8;
   localparam int DEF_CHANNELS = 3;

   localparam int DEF_ROW_W = $clog2(DEF_ROWS);
   localparam int DEF_COL_W = $clog2(DEF_COLS);
   localparam int DEF_CH_W  = $clog2(DEF_CHANNELS);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // A dimension of size 1 still needs a one-bit counter.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tensor_addr_gen.sv
`default_nettype none
// ============================================================================
// tensor_addr_gen : nested row/col/ch element counter, channel fastest
// Rev 1.0
// ============================================================================
module tensor_addr_gen
   import tensor_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int COLS     = DEF_COLS,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int ROW_W    = idx_w(DEF_ROWS),
   parameter int COL_W    = idx_w(DEF_COLS),
   parameter int CH_W     = idx_w(DEF_CHANNELS)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic [CH_W-1:0]  ch,
   output logic             last_elem
);

   logic row_end;
   logic col_end;
   logic ch_end;

   assign row_end   = (row == ROW_W'(ROWS - 1));
   assign col_end   = (col == COL_W'(COLS - 1));
   assign ch_end    = (ch  == CH_W'(CHANNELS - 1));
   assign last_elem = row_end && col_end && ch_end;

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         row <= '0;
         col <= '0;
         ch  <= '0;
      end else if (inc) begin
         if (ch_end) begin
            ch <= '0;
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end else begin
            ch <= ch + CH_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tensor_stream_builder.sv
`default_nettype none
// ============================================================================
// tensor_stream_builder : serial element stream -> parallel tensor handoff.
// Optional TENSOR_PINGPONG_EN adds a second bank so filling overlaps readout.
// Rev 1.0
// ============================================================================
module tensor_stream_builder
   import tensor_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ROWS     = DEF_ROWS,
   parameter int COLS     = DEF_COLS,
   parameter int CHANNELS = DEF_CHANNELS
)(
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [WIDTH-1:0]                                 in_data,
   input  logic                                             in_valid,
   input  logic                                             in_last,
   output logic                                             in_ready,
   output logic [ROWS-1:0][COLS-1:0][CHANNELS-1:0][WIDTH-1:0] tensor,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [$clog2(ROWS*COLS*CHANNELS+1)-1:0]          fill_count,
   output logic                                             len_err
);

   localparam int N_ELEM = ROWS * COLS * CHANNELS;
   localparam int FC_W   = $clog2(N_ELEM + 1);
   localparam int ROW_W  = idx_w(ROWS);
   localparam int COL_W  = idx_w(COLS);
   localparam int CH_W   = idx_w(CHANNELS);

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [CH_W-1:0]  ch;
   logic             last_elem;
   logic             accept;
   logic             early;
   logic             missing;
   logic             hs;
   logic             cnt_inc;
   logic             cnt_clear;

   assign accept  = in_valid && in_ready;
   assign early   = accept && in_last && !last_elem;
   assign missing = accept && !in_last && last_elem;
   assign hs      = out_valid && out_ready;
   assign cnt_inc = accept && !early;

   tensor_addr_gen #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .CHANNELS (CHANNELS),
      .ROW_W    (ROW_W),
      .COL_W    (COL_W),
      .CH_W     (CH_W)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .inc       (cnt_inc),
      .row       (row),
      .col       (col),
      .ch        (ch),
      .last_elem (last_elem)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_err <= 1'b0;
      end else begin
         len_err <= early || missing;
      end
   end

`ifdef TENSOR_PINGPONG_EN

   logic [1:0][ROWS-1:0][COLS-1:0][CHANNELS-1:0][WIDTH-1:0] bank;
   logic [1:0] full;
   logic       pres;
   logic       pres_n;
   logic       fill;
   logic       other;
   logic       swap;

   assign pres_n = ~pres;
   assign other  = ~fill;
   // Completed bank goes straight to the output when the other bank is
   // free or is being handed off in this very cycle.
   assign swap      = !full[other] || (hs && (pres == other));
   assign out_valid = full[pres];
   assign tensor    = bank[pres];
   assign in_ready  = rst && !(&full);
   assign cnt_clear = early;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bank <= '0;
         full <= '0;
         pres <= 1'b0;
         fill <= 1'b0;
      end else begin
         if (accept) begin
            bank[fill][row][col][ch] <= in_data;
         end
         if (hs) begin
            full[pres] <= 1'b0;
         end
         if (accept && last_elem) begin
            full[fill] <= 1'b1;
            if (swap) begin
               pres <= fill;
               fill <= other;
            end
         end else if (hs && full[pres_n]) begin
            pres <= pres_n;
            fill <= pres;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_count <= '0;
      end else if (early) begin
         fill_count <= '0;
      end else if (accept && last_elem) begin
         fill_count <= swap ? '0 : FC_W'(N_ELEM);
      end else if (accept) begin
         fill_count <= fill_count + FC_W'(1);
      end else if (hs && (&full)) begin
         fill_count <= '0;
      end
   end

`else

   logic [ROWS-1:0][COLS-1:0][CHANNELS-1:0][WIDTH-1:0] bank;
   state_t state;
   state_t state_nxt;

   assign in_ready  = rst && (state == FILL);
   assign out_valid = (state == FULL);
   assign tensor    = bank;
   assign cnt_clear = early || hs;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && last_elem) state_nxt = FULL;
         FULL:    if (out_ready) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bank <= '0;
      end else if (accept) begin
         bank[row][col][ch] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_count <= '0;
      end else if (early || hs) begin
         fill_count <= '0;
      end else if (accept) begin
         fill_count <= fill_count + FC_W'(1);
      end
   end

`endif

endmodule
`default_nettype wire

// File: tb/tb_tensor_stream_builder.sv
`default_nettype none
// ============================================================================
// tb_tensor_stream_builder : directed frames, scoreboard on tensor handoffs
// Rev 1.0
// ============================================================================
module tb_tensor_stream_builder;

   localparam int WIDTH    = 17;
   localparam int ROWS     = 8;
   localparam int COLS     = 8;
   localparam int CHANNELS = 3;
   localparam int N_ELEM   = ROWS * COLS * CHANNELS;
   localparam int FC_W     = $clog2(N_ELEM + 1);

   typedef logic [ROWS-1:0][COLS-1:0][CHANNELS-1:0][WIDTH-1:0] tensor_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   tensor_t          tensor;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [FC_W-1:0]  fill_count;
   logic             len_err;

   int n_chk    = 0;
   int n_fail   = 0;
   int n_lenerr = 0;
   int le       = 0;
   int guard    = 0;

   tensor_t exp_q[$];
   tensor_t mon_exp;
   int      mon_bad;

   always #5 clk = ~clk;

   tensor_stream_builder #(
      .WIDTH    (WIDTH),
      .ROWS     (ROWS),
      .COLS     (COLS),
      .CHANNELS (CHANNELS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .tensor     (tensor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fill_count (fill_count),
      .len_err    (len_err)
   );

   function automatic tensor_t build_frame(input int base);
      tensor_t f;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int h = 0; h < CHANNELS; h++)
               f[r][c][h] = WIDTH'(base + r * COLS * CHANNELS + c * CHANNELS + h);
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [WIDTH-1:0] d, input logic l);
      int g;
      g = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && g < 500) begin
         tick();
         g++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL beat_timeout: in_ready got 0 required 1");
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int base, input int nbeats, input int last_at);
      for (int i = 0; i < nbeats; i++)
         beat(WIDTH'(base + i), (i == last_at));
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Scoreboard monitor: every tensor handoff is matched against the queue.
   always @(negedge clk) begin
      if (len_err) n_lenerr++;
      if (rst && out_valid && out_ready) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_order: got an unexpected frame, required none");
         end else begin
            mon_exp = exp_q.pop_front();
            mon_bad = 0;
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++)
                  for (int h = 0; h < CHANNELS; h++)
                     if (tensor[r][c][h] !== mon_exp[r][c][h]) begin
                        if (mon_bad == 0)
                           $display("FAIL frame_data: elem[%0d][%0d][%0d] got %0d required %0d",
                                    r, c, h, tensor[r][c][h], mon_exp[r][c][h]);
                        mon_bad++;
                     end
            if (mon_bad != 0) n_fail++;
         end
      end
   end

   initial begin
      rst = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_fill_count", fill_count, 0);
      check("rst_len_err", len_err, 0);
      check("rst_tensor_zero", tensor == '0, 1);
      check("rst_in_ready_low", in_ready, 0);
      rst = 1'b1;
      tick();
      check("in_ready_after_rst", in_ready, 1);

`ifdef TENSOR_PINGPONG_EN
      exp_q.push_back(build_frame(100));
      exp_q.push_back(build_frame(200));
      exp_q.push_back(build_frame(300));
      send_frame(100, N_ELEM, N_ELEM - 1);
      check("t6_a_valid", out_valid, 1);
      check("t6_a_in_ready", in_ready, 1);
      check("t6_a_fill_next_bank", fill_count, 0);
      send_frame(200, N_ELEM, N_ELEM - 1);
      check("t6_blocked", in_ready, 0);
      check("t6_fill_saturated", fill_count, N_ELEM);
      check("t6_present_a", tensor[0][0][0], 100);
      out_ready = 1'b1;
      tick();
      check("t6_no_bubble", out_valid, 1);
      check("t6_present_b", tensor[2][5][1], 264);
      check("t6_unblocked", in_ready, 1);
      check("t6_fill_restart", fill_count, 0);
      send_frame(300, N_ELEM, N_ELEM - 1);
      check("t6_c_valid", out_valid, 1);
      check("t6_present_c", tensor[7][7][2], 491);
      tick();
      out_ready = 1'b0;
      check("t6_no_len_err", n_lenerr, 0);
`else
      // Test 1: full frame held while the consumer stalls.
      exp_q.push_back(build_frame(0));
      send_frame(0, N_ELEM - 1, -1);
      check("t1_valid_before_last", out_valid, 0);
      check("t1_fill_before_last", fill_count, N_ELEM - 1);
      beat(WIDTH'(N_ELEM - 1), 1'b1);
      check("t1_valid_latency", out_valid, 1);
      check("t1_fill_full", fill_count, N_ELEM);
      check("t1_elem_2_5_1", tensor[2][5][1], 64);
      repeat (4) tick();
      check("t1_in_ready_held", in_ready, 0);
      check("t1_valid_held", out_valid, 1);
      check("t1_no_len_err", n_lenerr, 0);

      // Test 2: handoff returns to filling, contents retained.
      consume();
      check("t2_valid_cleared", out_valid, 0);
      check("t2_in_ready", in_ready, 1);
      check("t2_fill_zero", fill_count, 0);
      check("t2_tensor_kept", tensor[2][5][1], 64);
      check("t2_tensor_kept_last", tensor[7][7][2], 191);

      // Test 3: early in_last drops the partial frame.
      le = n_lenerr;
      send_frame(1000, 11, 10);
      check("t3_fill_dropped", fill_count, 0);
      check("t3_no_valid", out_valid, 0);
      repeat (2) tick();
      check("t3_len_err_once", n_lenerr - le, 1);
      check("t3_still_no_valid", out_valid, 0);
      exp_q.push_back(build_frame(2000));
      le = n_lenerr;
      send_frame(2000, N_ELEM, N_ELEM - 1);
      check("t3_frame_valid", out_valid, 1);
      check("t3_elem_0_0_0", tensor[0][0][0], 2000);
      tick();
      check("t3_clean_len", n_lenerr - le, 0);
      consume();

      // Test 4: missing in_last still completes.
      le = n_lenerr;
      exp_q.push_back(build_frame(3000));
      send_frame(3000, N_ELEM, -1);
      check("t4_valid", out_valid, 1);
      repeat (2) tick();
      check("t4_len_err_once", n_lenerr - le, 1);
      consume();

      // Test 5: reset mid-frame.
      send_frame(4000, 100, -1);
      check("t5_fill_100", fill_count, 100);
      rst = 1'b0;
      tick();
      check("t5_tensor_cleared", tensor == '0, 1);
      check("t5_fill_zero", fill_count, 0);
      check("t5_in_ready_low", in_ready, 0);
      tick();
      check("t5_in_ready_still_low", in_ready, 0);
      rst = 1'b1;
      tick();
      exp_q.push_back(build_frame(5000));
      send_frame(5000, N_ELEM, N_ELEM - 1);
      check("t5_fresh_valid", out_valid, 1);
      check("t5_fresh_elem", tensor[1][0][0], 5024);
      consume();
`endif

      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         tick();
         guard++;
      end
      check("frames_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tensor_stream_builder.md
Name: tensor_stream_builder

Overview:
- Assembles a ROWS x COLS x CHANNELS tensor of WIDTH-bit elements from a serial valid/ready input stream.
- Generates element addresses internally, in channel-fastest raster order.
- Presents the completed tensor in parallel to the downstream compute stage through a valid/ready handshake.
- Checks frame length against in_last and flags mismatches.

Parameters:
- WIDTH, 17, element width in bits.
- ROWS, 8, tensor rows.
- COLS, 8, tensor columns.
- CHANNELS, 3, channels per pixel.
- N_ELEM, ROWS*COLS*CHANNELS, derived element count per frame. Not to be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  WIDTH  element data.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final element of a frame. Sampled only on an accepted beat.
- in_ready  out  1  the block can accept a beat.
- tensor  out  [ROWS][COLS][CHANNELS] x WIDTH  assembled tensor, indexed [row][col][ch].
- out_valid  out  1  tensor holds a complete frame.
- out_ready  in  1  consumer accepts the tensor.
- fill_count  out  $clog2(N_ELEM+1)  elements accepted into the bank currently filling.
- len_err  out  1  one-cycle pulse on a frame-length mismatch.

Behaviour:
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - The element is written at (row, col, ch); ch increments first, then col, then row.
  - Each counter wraps to 0 at its limit and carries into the next.
- Reset (rst == 0 at a clock edge):
  - All tensor elements are cleared to 0; out_valid, len_err and fill_count go to 0.
  - Counters go to 0 and the FSM goes to FILL.
  - in_ready is forced to 0 while rst is low.
  - Reset mid-frame discards the partial frame.
- FSM states, single-bank build:
  - FILL: in_ready = 1, out_valid = 0.
  - FILL -> FULL: on acceptance of element N_ELEM-1.
  - FULL: in_ready = 0, out_valid = 1; tensor is stable.
  - FULL -> FILL: on out_valid && out_ready. Counters and fill_count return to 0; tensor contents are retained and not cleared.
- Latency: out_valid rises on the cycle after the final beat is accepted.
- No same-cycle handshake overlap: while in FULL, no beat is accepted, even in the cycle of the output handshake.
- Early in_last (on an element index < N_ELEM-1):
  - len_err pulses for one cycle.
  - The partial frame is dropped: counters reset to 0, the FSM stays in FILL, out_valid is not raised.
- Missing in_last on element N_ELEM-1:
  - len_err pulses for one cycle.
  - The frame still completes normally and goes to FULL.
- out_ready while out_valid == 0 has no effect.
- fill_count equals the number of accepted beats in the current frame; it saturates at N_ELEM in FULL.

Optional Feature:
- Macro: TENSOR_PINGPONG_EN.
- When defined: two tensor banks.
  - One bank fills while the other is presented on tensor.
  - Completing a bank while the other bank is not presented makes the completed bank the presented one on the next cycle, and filling continues into the free bank.
  - in_ready = 0 only when both banks are complete and one is still awaiting out_ready.
  - If the presented bank's handshake and the other bank's completion occur in the same cycle, the new bank is presented on the next cycle with no out_valid bubble.
  - Reset clears both banks and selects bank 0 for filling.
- When undefined: the single-bank FILL/FULL behaviour above; no second bank exists in the RTL.

Decomposition:
- Package tensor_pkg:
  - Default ROWS/COLS/CHANNELS/WIDTH localparams.
  - FSM state enum (FILL, FULL).
  - Index widths: $clog2 of each dimension.
- Sub-module tensor_addr_gen:
  - Nested row/col/ch counter with increment enable, synchronous clear, and a last_elem flag.
  - Instantiated once per builder.

Test Plan:
1. Stream 192 beats, data = index 0..191, in_last on beat 191, out_ready = 0.
   - out_valid = 1 one cycle after beat 191.
   - tensor[2][5][1] = 2*24 + 5*3 + 1 = 64.
   - in_ready = 0 until out_ready is asserted.
2. After test 1, pulse out_ready.
   - Next cycle: out_valid = 0, in_ready = 1, fill_count = 0, tensor still holds the old data.
3. Assert in_last on beat 10.
   - len_err pulses once; fill_count = 0; out_valid stays 0.
   - A following full 192-beat frame completes normally.
4. Send 192 beats with in_last never asserted.
   - len_err pulses on beat 191; out_valid = 1 on the next cycle.
5. Drive rst = 0 after 100 beats.
   - Next edge: all tensor elements = 0, fill_count = 0, in_ready = 0 while rst is low.
   - A fresh frame then builds correctly.
6. With TENSOR_PINGPONG_EN, stream 3 back-to-back frames, out_ready = 0 for frame 1 only.
   - in_ready drops after frame 2 completes.
   - Releasing out_ready presents frame 2 with no bubble; all frames are observed in order.
